// File: rtl/inv_shift_row_pkg.sv
// Shared AES state constants and the ShiftRows / InvShiftRows byte-permutation helpers.
// State is column-major: byte k sits at state[127-8k -: 8], row k%4, column k/4.
package inv_shift_row_pkg;

  localparam int unsigned AES_STATE_W   = 128;
  localparam int unsigned AES_NUM_BYTES = 16;

  typedef logic [AES_STATE_W-1:0] aes_state_t;

  // Source byte index feeding output byte k under InvShiftRows (row r rotated right by r).
  function automatic int unsigned inv_src_idx(input int unsigned k);
    int unsigned r;
    int unsigned c;
    r = k % 4;
    c = k / 4;
    return r + 4 * ((c + 4 - r) % 4);
  endfunction

  // Source byte index feeding output byte k under ShiftRows (row r rotated left by r).
  function automatic int unsigned fwd_src_idx(input int unsigned k);
    int unsigned r;
    int unsigned c;
    r = k % 4;
    c = k / 4;
    return r + 4 * ((c + r) % 4);
  endfunction

  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int unsigned k = 0; k < AES_NUM_BYTES; k++) begin
      o[127-8*k -: 8] = s[127-8*inv_src_idx(k) -: 8];
    end
    return o;
  endfunction

  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int unsigned k = 0; k < AES_NUM_BYTES; k++) begin
      o[127-8*k -: 8] = s[127-8*fwd_src_idx(k) -: 8];
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_shift_row_if.sv
// Data/enable bundle between the upstream round stage and inv_shift_row.
interface inv_shift_row_if;
  import inv_shift_row_pkg::*;

  logic       startTransition;
  aes_state_t inputData;
  aes_state_t outputData;
  logic       outputValid;

  modport master (
    output startTransition,
    output inputData,
    input  outputData,
    input  outputValid
  );

  modport slave (
    input  startTransition,
    input  inputData,
    output outputData,
    output outputValid
  );

endinterface

// File: rtl/inv_shift_row_perm.sv
// Combinational InvShiftRows: a fixed byte rewiring, no logic gates.
module inv_shift_row_perm
  import inv_shift_row_pkg::*;
(
  input  aes_state_t state_i,
  output aes_state_t state_o
);

  for (genvar k = 0; k < AES_NUM_BYTES; k++) begin : g_byte
    localparam int unsigned Src = inv_src_idx(k);
    assign state_o[127-8*k -: 8] = state_i[127-8*Src -: 8];
  end

endmodule

// File: rtl/inv_shift_row.sv
// Registered AES InvShiftRows stage: captures the permuted state when startTransition is high.
module inv_shift_row
  import inv_shift_row_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  inv_shift_row_if.slave       bus
);

  aes_state_t perm;
  aes_state_t data_d, data_q;
  logic       valid_d, valid_q;

  inv_shift_row_perm u_perm (
    .state_i (bus.inputData),
    .state_o (perm)
  );

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (bus.startTransition) begin
      data_d  = perm;
      valid_d = 1'b1;
    end
  end

  // Reset wins over a simultaneous capture request.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.outputData  = data_q;
  assign bus.outputValid = valid_q;

endmodule

// File: tb/tb_inv_shift_row.sv
// Self-checking bench for inv_shift_row: vector table, corner sequences, random round trips.
module tb_inv_shift_row;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  inv_shift_row_if bus ();

  inv_shift_row dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [127:0] data;
    logic         valid;
    string        name;
  } exp_t;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    string        name;
  } vec_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [127:0] FipsIn  = 128'h2b30c0a0cbab929f20c793eba2af2f63;
  localparam logic [127:0] FipsOut = 128'h2baf939fcb302feb20abc063a2c792a0;
  localparam logic [127:0] IdxIn   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IdxOut  = 128'h000d0a0704010e0b0805020f0c090603;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Independent forward ShiftRows: out[r][c] = in[r][(c+r) mod 4].
  function automatic logic [127:0] ref_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = s[127-8*((k % 4) + 4 * (((k / 4) + (k % 4)) % 4)) -: 8];
    end
    return o;
  endfunction

  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty: got nothing to compare, need an entry");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (bus.outputData !== e.data) begin
      n_fail++;
      $display("FAIL %s data: got %h need %h", e.name, bus.outputData, e.data);
    end
    n_cmp++;
    if (bus.outputValid !== e.valid) begin
      n_fail++;
      $display("FAIL %s valid: got %b need %b", e.name, bus.outputValid, e.valid);
    end
  endtask

  // Drive one cycle's inputs, queue what the outputs must be after the edge, then compare.
  task automatic step(input logic rst, input logic st, input logic [127:0] din,
                      input logic [127:0] exp_d, input logic exp_v, input string name);
    reset               = rst;
    bus.startTransition = st;
    bus.inputData       = din;
    sb.push_back('{exp_d, exp_v, name});
    @(posedge clock);
    #1;
    check_one();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, need $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs[$];
    logic [127:0] s;
    logic [127:0] prev;

    vecs.push_back('{FipsIn, FipsOut, "fips"});
    vecs.push_back('{IdxIn, IdxOut, "index"});
    vecs.push_back('{128'h0, 128'h0, "zeros"});
    vecs.push_back('{{128{1'b1}}, {128{1'b1}}, "ones"});
    vecs.push_back('{128'haa000000000000000000000000000000,
                     128'haa000000000000000000000000000000, "byte0"});
    vecs.push_back('{128'h00bb0000000000000000000000000000,
                     128'h0000000000bb00000000000000000000, "byte1"});
    vecs.push_back('{128'h00000011000000000000000000000000,
                     128'h00000000000000000000000000000011, "byte3"});
    vecs.push_back('{128'h000000000000000000000000000000cc,
                     128'h0000000000000000000000cc00000000, "byte15"});

    reset               = 1'b1;
    bus.startTransition = 1'b0;
    bus.inputData       = '0;

    // Reset, including priority over a simultaneous capture.
    step(1'b1, 1'b0, 128'h0, 128'h0, 1'b0, "reset_idle");
    step(1'b1, 1'b1, FipsIn, 128'h0, 1'b0, "reset_prio");
    step(1'b1, 1'b1, FipsIn, 128'h0, 1'b0, "reset_prio2");
    step(1'b0, 1'b1, FipsIn, FipsOut, 1'b1, "post_reset");

    // Hold: no capture, input changes ignored, valid drops.
    step(1'b0, 1'b0, {128{1'b1}}, FipsOut, 1'b0, "hold_ones");
    step(1'b0, 1'b0, IdxIn, FipsOut, 1'b0, "hold_idx");

    // Table vectors, back-to-back.
    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, 1'b1, vecs[i].din, vecs[i].dout, 1'b1, vecs[i].name);
    end

    // Mid-stream reset, then nothing captured until start returns.
    step(1'b0, 1'b1, IdxIn, IdxOut, 1'b1, "pre_mid_reset");
    step(1'b1, 1'b1, FipsIn, 128'h0, 1'b0, "mid_reset");
    step(1'b0, 1'b0, FipsIn, 128'h0, 1'b0, "no_start_after_reset");
    step(1'b0, 1'b1, IdxIn, IdxOut, 1'b1, "first_after_reset");

    // Round trip: InvShiftRows(ShiftRows(s)) == s, start held high throughout.
    for (int i = 0; i < 1000; i++) begin
      s = rand128();
      step(1'b0, 1'b1, ref_shift(s), s, 1'b1, "round_trip");
    end
    prev = s;

    // Long idle stretch with wandering input, then a capture.
    for (int i = 0; i < 520; i++) begin
      step(1'b0, 1'b0, rand128(), prev, 1'b0, "long_idle");
    end
    step(1'b0, 1'b1, FipsIn, FipsOut, 1'b1, "after_idle");
    step(1'b0, 1'b0, 128'h0, FipsOut, 1'b0, "after_idle_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
